// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment/extension and write-back select.
// Drives the register file write port combinationally and counts retired instructions.
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        me_valid,
  input  logic [4:0]  me_rd,
  input  logic        me_regwrite,
  input  logic [1:0]  me_wb_sel,
  input  logic [2:0]  me_funct3,
  input  logic [31:0] me_alu_result,
  input  logic [31:0] me_pc_plus4,
  input  logic [31:0] mem_rdata,
  input  logic        wb_stall,
  input  logic        wb_flush,
  output logic [4:0]  w_regs_addr,
  output logic [31:0] w_regs_data,
  output logic        w_regs_en,
  output logic        wb_valid,
  output logic        wb_misalign,
  output logic [31:0] instret
);

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
  } wb_reg_t;

  wb_reg_t     wb_q;
  logic [31:0] rdata_hold;
  logic        hold_vld;
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_q       <= '0;
      rdata_hold <= '0;
      hold_vld   <= 1'b0;
    end else if (wb_flush) begin
      wb_q.valid <= 1'b0;
      hold_vld   <= 1'b0;
    end else if (wb_stall) begin
      // Memory only presents the read word once; keep the first-cycle value.
      if (!hold_vld) begin
        rdata_hold <= mem_rdata;
        hold_vld   <= 1'b1;
      end
    end else begin
      wb_q.valid      <= me_valid;
      wb_q.regwrite   <= me_regwrite;
      wb_q.rd         <= me_rd;
      wb_q.wb_sel     <= me_wb_sel;
      wb_q.funct3     <= me_funct3;
      wb_q.alu_result <= me_alu_result;
      wb_q.pc_plus4   <= me_pc_plus4;
      hold_vld        <= 1'b0;
    end
  end

  logic [31:0] raw;
  logic [1:0]  off;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic        is_half;
  logic        is_word;

  always_comb begin
    raw = hold_vld ? rdata_hold : mem_rdata;
    off = wb_q.alu_result[1:0];
    case (off)
      2'd0:    byte_lane = raw[7:0];
      2'd1:    byte_lane = raw[15:8];
      2'd2:    byte_lane = raw[23:16];
      default: byte_lane = raw[31:24];
    endcase
    half_lane = off[1] ? raw[31:16] : raw[15:0];
    case (wb_q.funct3)
      3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b100:  load_data = {24'd0, byte_lane};
      3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b101:  load_data = {16'd0, half_lane};
      default: load_data = raw;
    endcase
  end

  // funct3[1] set covers LW and the reserved codes, all treated as word loads.
  assign is_half     = (wb_q.funct3[1:0] == 2'b01);
  assign is_word     = wb_q.funct3[1];
  assign wb_misalign = wb_q.valid & (wb_q.wb_sel == 2'b01) &
                       ((is_half & off[0]) | (is_word & (off != 2'd0)));

  always_comb begin
    case (wb_q.wb_sel)
      2'b01:   w_regs_data = load_data;
      2'b10:   w_regs_data = wb_q.pc_plus4;
      default: w_regs_data = wb_q.alu_result;
    endcase
  end

  assign w_regs_addr = wb_q.rd;
  assign w_regs_en   = wb_q.valid & wb_q.regwrite & (wb_q.rd != 5'd0) & ~wb_misalign;
  assign wb_valid    = wb_q.valid;

  always_ff @(posedge clk) begin
    if (!rst)
      instret_q <= '0;
    else if (wb_q.valid & ~wb_stall & ~wb_misalign)
      instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed test-plan cases, then random traffic
// checked against an instruction-level reference model.
module tb_mem_wb_stage;

  logic        clk, rst;
  logic        me_valid, me_regwrite;
  logic [4:0]  me_rd;
  logic [1:0]  me_wb_sel;
  logic [2:0]  me_funct3;
  logic [31:0] me_alu_result, me_pc_plus4, mem_rdata;
  logic        wb_stall, wb_flush;
  logic [4:0]  w_regs_addr;
  logic [31:0] w_regs_data, instret;
  logic        w_regs_en, wb_valid, wb_misalign;

  mem_wb_stage dut (
    .clk(clk), .rst(rst),
    .me_valid(me_valid), .me_rd(me_rd), .me_regwrite(me_regwrite),
    .me_wb_sel(me_wb_sel), .me_funct3(me_funct3),
    .me_alu_result(me_alu_result), .me_pc_plus4(me_pc_plus4),
    .mem_rdata(mem_rdata), .wb_stall(wb_stall), .wb_flush(wb_flush),
    .w_regs_addr(w_regs_addr), .w_regs_data(w_regs_data), .w_regs_en(w_regs_en),
    .wb_valid(wb_valid), .wb_misalign(wb_misalign), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] pc4;
  } ins_t;

  int total = 0;
  int bad   = 0;

  ins_t        m;
  logic        m_known, m_init;
  logic [31:0] m_word, m_inst;
  logic [31:0] saved;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld(input logic [2:0] f3, input logic [31:0] raw,
                                     input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(raw >> (8 * off));
    h = 16'(raw >> (16 * off[1]));
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd4:    return 32'(b);
      3'd1:    return 32'($signed(h));
      3'd5:    return 32'(h);
      default: return raw;
    endcase
  endfunction

  function automatic logic is_mis(input ins_t x);
    logic half, word;
    half = (x.f3 == 3'd1) || (x.f3 == 3'd5);
    word = !(x.f3 inside {3'd0, 3'd1, 3'd4, 3'd5});
    return x.v && x.sel == 2'b01 &&
           ((half && x.alu[0]) || (word && x.alu[1:0] != 2'd0));
  endfunction

  function automatic logic [31:0] wdata(input ins_t x, input logic [31:0] raw);
    if (x.sel == 2'b01) return ld(x.f3, raw, x.alu[1:0]);
    if (x.sel == 2'b10) return x.pc4;
    return x.alu;
  endfunction

  // Compare against the model, advance the model over the coming edge,
  // and return at the next negedge.
  task automatic tick();
    logic [31:0] raw;
    logic        mis;
    #1;
    raw = m_known ? m_word : mem_rdata;
    mis = is_mis(m);
    if (m_init) begin
      chk("m_valid", 32'(wb_valid), 32'(m.v));
      chk("m_misalign", 32'(wb_misalign), 32'(mis));
      chk("m_en", 32'(w_regs_en), 32'(m.v && m.rw && m.rd != 5'd0 && !mis));
      chk("m_instret", instret, m_inst);
      if (m.v) begin
        chk("m_addr", 32'(w_regs_addr), 32'(m.rd));
        chk("m_data", w_regs_data, wdata(m, raw));
      end
    end
    if (!rst) begin
      m = '0; m_known = 1'b0; m_word = '0; m_inst = '0; m_init = 1'b1;
    end else begin
      if (m.v && !wb_stall && !mis) m_inst = m_inst + 32'd1;
      if (wb_flush) begin
        m.v = 1'b0; m_known = 1'b0;
      end else if (wb_stall) begin
        if (!m_known) begin m_word = mem_rdata; m_known = 1'b1; end
      end else begin
        m = {me_valid, me_rd, me_regwrite, me_wb_sel, me_funct3, me_alu_result, me_pc_plus4};
        m_known = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setin(input logic v, input logic [4:0] rd, input logic rw,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc4);
    me_valid = v; me_rd = rd; me_regwrite = rw; me_wb_sel = sel;
    me_funct3 = f3; me_alu_result = alu; me_pc_plus4 = pc4;
  endtask

  initial begin
    m = '0; m_known = 1'b0; m_word = '0; m_inst = '0; m_init = 1'b0;
    rst = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0; mem_rdata = '0;
    setin(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_en", 32'(w_regs_en), 32'd0);
    chk("rst_addr", 32'(w_regs_addr), 32'd0);
    chk("rst_data", w_regs_data, 32'd0);
    chk("rst_mis", 32'(wb_misalign), 32'd0);
    chk("rst_instret", instret, 32'd0);

    // ALU op
    setin(1, 5, 1, 2'b00, 3'd0, 32'h1234_5678, 32'd0);
    tick();
    setin(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("alu_en", 32'(w_regs_en), 32'd1);
    chk("alu_addr", 32'(w_regs_addr), 32'd5);
    chk("alu_data", w_regs_data, 32'h1234_5678);
    chk("alu_instret0", instret, 32'd0);
    tick();
    chk("alu_instret1", instret, 32'd1);

    // Byte/half loads from 0x80FF7F01
    begin
      logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
      logic [1:0]  offs[4] = '{2'd2, 2'd3, 2'd2, 2'd0};
      logic [31:0] exps[4] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
      for (int i = 0; i < 4; i++) begin
        setin(1, 4, 1, 2'b01, f3s[i], {30'h40, offs[i]}, 32'd0);
        tick();
        setin(0, 0, 0, 0, 0, 0, 0);
        mem_rdata = 32'h80FF_7F01;
        #1;
        chk($sformatf("load%0d_data", i), w_regs_data, exps[i]);
        chk($sformatf("load%0d_en", i), 32'(w_regs_en), 32'd1);
      end
    end

    // Misaligned LW and LH
    for (int i = 0; i < 2; i++) begin
      if (i == 0) setin(1, 7, 1, 2'b01, 3'd2, 32'h1002, 32'd0);
      else        setin(1, 7, 1, 2'b01, 3'd1, 32'h1001, 32'd0);
      tick();
      setin(0, 0, 0, 0, 0, 0, 0);
      saved = instret;
      #1;
      chk($sformatf("mis%0d_flag", i), 32'(wb_misalign), 32'd1);
      chk($sformatf("mis%0d_en", i), 32'(w_regs_en), 32'd0);
      tick();
      chk($sformatf("mis%0d_instret", i), instret, saved);
    end

    // Stall with data hold
    setin(1, 3, 1, 2'b01, 3'd2, 32'h200, 32'd0);
    tick();
    setin(0, 0, 0, 0, 0, 0, 0);
    saved = instret;
    mem_rdata = 32'hCAFE_BABE;
    wb_stall = 1'b1;
    tick();
    mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall_data", w_regs_data, 32'hCAFE_BABE);
      chk("stall_en", 32'(w_regs_en), 32'd1);
      tick();
    end
    wb_stall = 1'b0;
    #1;
    chk("stall_data_rel", w_regs_data, 32'hCAFE_BABE);
    chk("stall_instret_hold", instret, saved);
    tick();
    chk("stall_instret_inc", instret, saved + 32'd1);

    // Flush overriding stall
    setin(1, 9, 1, 2'b00, 3'd0, 32'h55, 32'd0);
    tick();
    wb_flush = 1'b1; wb_stall = 1'b1;
    tick();
    wb_flush = 1'b0; wb_stall = 1'b0;
    chk("flush_valid", 32'(wb_valid), 32'd0);
    chk("flush_en", 32'(w_regs_en), 32'd0);

    // x0 destination still retires
    setin(1, 0, 1, 2'b00, 3'd0, 32'h77, 32'd0);
    tick();
    setin(0, 0, 0, 0, 0, 0, 0);
    saved = instret;
    #1;
    chk("x0_en", 32'(w_regs_en), 32'd0);
    tick();
    chk("x0_instret", instret, saved + 32'd1);

    // JAL link value
    setin(1, 1, 1, 2'b10, 3'd0, 32'h9999, 32'h0000_0104);
    tick();
    setin(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("jal_data", w_regs_data, 32'h104);
    chk("jal_en", 32'(w_regs_en), 32'd1);
    tick();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) != 0);
      wb_stall  = ($urandom_range(0, 3) == 0);
      wb_flush  = ($urandom_range(0, 11) == 0);
      mem_rdata = $urandom;
      setin(1'($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom),
            2'($urandom), 3'($urandom), $urandom, $urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
